// File: rtl/lram_line_buffer.sv
// lram_line_buffer: double-banked line RAM between the pixel compositor and the
// video sync/output stage. The compositor fills the hidden bank through a
// valid/ready stream, the sync stage reads the displayed bank, and the two
// banks swap roles on every HCOMP pulse. Words past the supplied line length
// are filled with the background colour. A line that is still being filled
// when the next HCOMP arrives is reported as an underrun.
module lram_line_buffer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int LINE_WORDS = 1024
) (
  input  logic              gclk,
  input  logic              rstn,
  input  logic              hcomp,
  input  logic              lramsel,
  input  logic [ADDR_W-1:0] lramadr,
  output logic [DATA_W-1:0] lramdat,
  input  logic [DATA_W-1:0] bg_color,
  input  logic [ADDR_W:0]   wr_len,
  output logic              line_req,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_dat,
  output logic              wr_ready,
  output logic              busy,
  output logic              underrun,
  output logic [15:0]       underrun_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_W:0] FULL_LEN  = LINE_WORDS[ADDR_W:0];
  localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] LAST_ADDR = FULL_LEN - PTR_ONE;

  state_e            state_q;
  logic              wbank_q;
  logic [ADDR_W:0]   wptr_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   len_d;
  logic [DATA_W-1:0] lramdat_q;
  logic              line_req_q;
  logic              busy_q;
  logic              underrun_q;
  logic [15:0]       underrun_cnt_q;

  // Both banks live in one array; the top address bit selects the bank.
  logic [DATA_W-1:0] mem_q [0:2*LINE_WORDS-1];

  logic              fill_acc;
  logic              clear_wr;
  logic              mem_we;
  logic [ADDR_W:0]   mem_waddr;
  logic [ADDR_W:0]   mem_raddr;
  logic [DATA_W-1:0] mem_wdat;

  // Clamp the requested line length to the bank size, sampled only at hcomp.
  always_comb begin
    len_d = (wr_len > FULL_LEN) ? FULL_LEN : wr_len;
  end

  // wr_ready has to drop in the hcomp cycle itself, so it is decoded from the
  // registered state and the live hcomp. A zero-length line never raises it.
  assign wr_ready  = (state_q == FILL) && !hcomp && (len_q != '0);
  assign fill_acc  = wr_valid && wr_ready;
  assign clear_wr  = (state_q == CLEAR) && !hcomp;
  assign mem_we    = fill_acc || clear_wr;
  assign mem_wdat  = (state_q == FILL) ? wr_dat : bg_color;
  assign mem_waddr = {wbank_q, wptr_q[ADDR_W-1:0]};
  assign mem_raddr = {lramsel, lramadr};

  // Fill/clear sequencer, underrun accounting and registered status outputs.
  // NOTE: all state here updates with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      wbank_q        <= 1'b0;
      wptr_q         <= '0;
      len_q          <= '0;
      line_req_q     <= 1'b0;
      busy_q         <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      line_req_q <= hcomp;
      underrun_q <= 1'b0;
      if (hcomp) begin
        // The bank shown up to now becomes the hidden bank once lramsel toggles.
        wbank_q <= lramsel;
        wptr_q  <= '0;
        len_q   <= len_d;
        state_q <= FILL;
        busy_q  <= 1'b1;
        if ((state_q == FILL) || (state_q == CLEAR)) begin
          underrun_q <= 1'b1;
          if (underrun_cnt_q != 16'hFFFF) begin
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
          end
        end
      end else begin
        case (state_q)
          FILL: begin
            if (len_q == '0) begin
              state_q <= CLEAR;
            end else if (fill_acc) begin
              wptr_q <= wptr_q + PTR_ONE;
              if (wptr_q == len_q - PTR_ONE) begin
                if (len_q == FULL_LEN) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                end else begin
                  state_q <= CLEAR;
                end
              end
            end
          end
          CLEAR: begin
            wptr_q <= wptr_q + PTR_ONE;
            if (wptr_q == LAST_ADDR) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Line RAM write port: source pixels during FILL, background during CLEAR.
  // NOTE: the RAM array has no reset so it maps onto block RAM; only its read register is reset.
  always_ff @(posedge gclk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdat;
    end
  end

  // Registered read of the displayed bank, one gclk of latency.
  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      lramdat_q <= '0;
    end else begin
      lramdat_q <= mem_q[mem_raddr];
    end
  end

  assign lramdat      = lramdat_q;
  assign line_req     = line_req_q;
  assign busy         = busy_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_lram_line_buffer.sv
// Self-checking bench for lram_line_buffer. The reference keeps the expected
// contents of both banks as plain arrays, updated per line from the rule
// "words below the clamped length hold the source pixels, the rest hold the
// background colour", and compares every read of the displayed bank.
module tb_lram_line_buffer;

  logic        gclk = 1'b0;
  logic        rstn;
  logic        hcomp;
  logic        lramsel;
  logic [9:0]  lramadr;
  logic [15:0] lramdat;
  logic [15:0] bg_color;
  logic [10:0] wr_len;
  logic        line_req;
  logic        wr_valid;
  logic [15:0] wr_dat;
  logic        wr_ready;
  logic        busy;
  logic        underrun;
  logic [15:0] underrun_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] cnt_exp;
  logic [15:0] mdl      [0:1][0:1023];
  logic [15:0] line_buf [0:1023];

  lram_line_buffer dut (
    .gclk         (gclk),
    .rstn         (rstn),
    .hcomp        (hcomp),
    .lramsel      (lramsel),
    .lramadr      (lramadr),
    .lramdat      (lramdat),
    .bg_color     (bg_color),
    .wr_len       (wr_len),
    .line_req     (line_req),
    .wr_valid     (wr_valid),
    .wr_dat       (wr_dat),
    .wr_ready     (wr_ready),
    .busy         (busy),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 gclk = ~gclk;

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: random read address, sample wr_ready before the edge, check
  // the registered read data after it against the displayed-bank model.
  task automatic rd_cycle(input bit rd_en, output bit rdy);
    logic [9:0] a;
    logic       s;
    a       = 10'($urandom);
    lramadr = a;
    s       = lramsel;
    #1;
    rdy = wr_ready;
    tick();
    if (rd_en && !$isunknown(mdl[s][a])) check("disp_word", lramdat, mdl[s][a]);
  endtask

  task automatic rd_fixed(input string tag, input logic [9:0] a, input logic [15:0] exp);
    lramadr = a;
    tick();
    check(tag, lramdat, exp);
  endtask

  // hcomp pulse; the sync stage toggles lramsel in the following cycle.
  task automatic hcomp_cycle(input bit v, input bit rd_en, input bit exp_ur, input logic [15:0] exp_cnt);
    bit rdy;
    hcomp    = 1'b1;
    wr_valid = v;
    rd_cycle(rd_en, rdy);
    check("hcomp_ready", rdy, 0);
    hcomp    = 1'b0;
    wr_valid = 1'b0;
    lramsel  = ~lramsel;
    check("line_req", line_req, 1);
    check("busy_after_hcomp", busy, 1);
    check("underrun", underrun, exp_ur);
    check("underrun_cnt", underrun_cnt, exp_cnt);
  endtask

  // Stream pixels line_buf[start..L-1] with random gaps, then wait for DONE.
  task automatic stream_rest(input int L, input int start, input int vpct, input bit rd_en,
                             output int clear_cycles);
    int acc;
    int guard;
    bit rdy;
    bit first;
    acc   = start;
    guard = 0;
    first = 1'b1;
    while (acc < L && guard < 5000) begin
      wr_valid = ($urandom_range(99) < vpct);
      wr_dat   = line_buf[acc];
      rd_cycle(rd_en, rdy);
      check("fill_ready", rdy, 1);
      if (wr_valid && rdy) acc++;
      if (first) begin
        check("line_req_width", line_req, 0);
        check("underrun_width", underrun, 0);
        first = 1'b0;
      end
      guard++;
    end
    check("fill_count", acc, L);
    wr_valid     = 1'b1;
    wr_dat       = 16'hBAD0;
    clear_cycles = 0;
    while (busy === 1'b1 && clear_cycles < 2000) begin
      rd_cycle(rd_en, rdy);
      check("clear_ready", rdy, 0);
      clear_cycles++;
    end
    wr_valid = 1'b0;
    check("line_done", busy, 0);
  endtask

  task automatic commit_line(input logic b, input int L, input logic [15:0] bg);
    for (int i = 0; i < 1024; i++) mdl[b][i] = (i < L) ? line_buf[i] : bg;
  endtask

  task automatic run_line(input int len_req, input logic [15:0] bg, input int vpct,
                          input bit pat_addr, output int cc);
    int   L;
    logic b;
    L = (len_req > 1024) ? 1024 : len_req;
    for (int i = 0; i < 1024; i++) line_buf[i] = pat_addr ? 16'(i) : 16'($urandom);
    wr_len   = 11'(len_req);
    bg_color = bg;
    b        = lramsel;
    hcomp_cycle(1'b0, 1'b1, 1'b0, cnt_exp);
    stream_rest(L, 0, vpct, 1'b1, cc);
    commit_line(b, L, bg);
  endtask

  initial begin
    int   cc;
    int   len_req;
    int   L;
    bit   rdy;
    logic b;

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 1024; j++) mdl[i][j] = 'x;
    hcomp    = 1'b0;
    lramsel  = 1'b0;
    lramadr  = '0;
    bg_color = '0;
    wr_len   = '0;
    wr_valid = 1'b0;
    wr_dat   = '0;
    cnt_exp  = '0;

    // Reset state
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1;
    check("rst_lramdat", lramdat, 0);
    check("rst_line_req", line_req, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_underrun_cnt", underrun_cnt, 0);
    tick();
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      rd_cycle(1'b0, rdy);
      check("idle_ready", rdy, 0);
      check("idle_busy", busy, 0);
    end
    wr_valid = 1'b0;

    // Test 1: 768-pixel line of address data into bank 0, then background tail
    run_line(768, 16'h1234, 100, 1'b1, cc);
    check("t1_clear_cycles", cc, 256);
    lramsel = 1'b0;
    rd_fixed("t1_rd5", 10'd5, 16'h0005);
    rd_fixed("t1_rd767", 10'd767, 16'h02FF);
    rd_fixed("t1_rd768", 10'd768, 16'h1234);
    rd_fixed("t1_rd1023", 10'd1023, 16'h1234);
    rd_fixed("t1_rd5_again", 10'd5, 16'h0005);
    lramsel = 1'b1;

    // Test 2: zero-length line -> whole bank background, wr_ready never high
    run_line(0, 16'h7FFE, 100, 1'b0, cc);
    check("t2_clear_cycles", (cc == 1024) || (cc == 1025), 1);

    // Test 3: full line and clamped over-length line, no CLEAR phase
    run_line(1024, 16'h0F0F, 60, 1'b0, cc);
    check("t3_full_no_clear", cc, 0);
    run_line(1500, 16'hF0F0, 80, 1'b0, cc);
    check("t3_clamp_no_clear", cc, 0);

    // Test 4: source stalls after 100 pixels, next hcomp is an underrun
    for (int i = 0; i < 1024; i++) line_buf[i] = 16'($urandom);
    wr_len   = 11'd512;
    bg_color = 16'h5555;
    b        = lramsel;
    hcomp_cycle(1'b0, 1'b1, 1'b0, cnt_exp);
    for (int i = 0; i < 100; i++) begin
      wr_valid = 1'b1;
      wr_dat   = line_buf[i];
      rd_cycle(1'b1, rdy);
      check("t4_ready", rdy, 1);
    end
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b0;
      rd_cycle(1'b1, rdy);
      check("t4_stall_ready", rdy, 1);
      check("t4_stall_busy", busy, 1);
    end
    for (int i = 0; i < 100; i++) mdl[b][i] = line_buf[i];
    for (int i = 0; i < 1024; i++) line_buf[i] = 16'($urandom);
    line_buf[0] = 16'h0BEE;
    wr_len      = 11'd1024;
    wr_dat      = 16'hDEAD;
    b           = lramsel;
    cnt_exp     = 16'd1;
    hcomp_cycle(1'b1, 1'b1, 1'b1, cnt_exp);
    stream_rest(1024, 0, 70, 1'b1, cc);
    check("t4_refill_no_clear", cc, 0);
    commit_line(b, 1024, bg_color);
    lramsel = b;
    rd_fixed("t4_first_word", 10'd0, 16'h0BEE);
    lramsel = ~b;

    // Test 5: random lengths, colours and valid gaps against the bank model
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(9))
        0:       len_req = 0;
        1:       len_req = 1024;
        2:       len_req = 1023;
        3:       len_req = 1;
        4:       len_req = 1024 + $urandom_range(1, 1023);
        default: len_req = $urandom_range(1, 1023);
      endcase
      L = (len_req > 1024) ? 1024 : len_req;
      run_line(len_req, 16'($urandom), $urandom_range(30, 100), 1'b0, cc);
      if (L == 0) check("t5_clear_cycles_zero", (cc == 1024) || (cc == 1025), 1);
      else        check("t5_clear_cycles", cc, 1024 - L);
    end
    check("t5_underrun_cnt", underrun_cnt, 1);

    // Test 6: reset in the middle of a fill, then counter saturation
    for (int i = 0; i < 1024; i++) line_buf[i] = 16'($urandom);
    wr_len = 11'd800;
    hcomp_cycle(1'b0, 1'b0, 1'b0, cnt_exp);
    for (int i = 0; i < 50; i++) begin
      wr_valid = 1'b1;
      wr_dat   = line_buf[i];
      rd_cycle(1'b0, rdy);
    end
    rstn = 1'b0;
    #1;
    cnt_exp = '0;
    check("t6_rst_lramdat", lramdat, 0);
    check("t6_rst_line_req", line_req, 0);
    check("t6_rst_wr_ready", wr_ready, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_underrun", underrun, 0);
    check("t6_rst_underrun_cnt", underrun_cnt, 0);
    tick();
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      rd_cycle(1'b0, rdy);
      check("t6_idle_ready", rdy, 0);
      check("t6_idle_busy", busy, 0);
    end
    wr_valid = 1'b0;
    hcomp_cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    force dut.underrun_cnt_q = 16'hFFFE;
    #1;
    release dut.underrun_cnt_q;
    hcomp_cycle(1'b0, 1'b0, 1'b1, 16'hFFFF);
    hcomp_cycle(1'b0, 1'b0, 1'b1, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
